// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, operand addresses and parser state type for the UART command parser.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FN,
        ST_WAIT_RSP
    } state_e;

endpackage

// File: rtl/uart_rx_cmd_parser.sv
// Command-frame parser between the UART receiver and the register file / ALU.
// Optional UART_CMD_ERR_DROP_EN: bytes flagged with parity/stop errors abort the frame and pulse FRAME_ERR.
module uart_rx_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_ERR,
    input  logic                  RX_STP_ERR,
    input  logic                  RSP_ACK,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  CLK_GATE_EN,
    output logic                  OVERRUN,
`ifdef UART_CMD_ERR_DROP_EN
    output logic                  FRAME_ERR,
`endif
    output logic                  BUSY
);

    state_e                state_q, state_d;
    logic                  rf_wr_en_q, rf_wr_en_d;
    logic                  rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
    logic                  alu_en_q, alu_en_d;
    logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
    logic                  clk_gate_en_q, clk_gate_en_d;
    logic                  overrun_q, overrun_d;
    logic                  busy_q, busy_d;
    logic                  byte_err_s;

`ifdef UART_CMD_ERR_DROP_EN
    logic                  frame_err_q, frame_err_d;
    assign byte_err_s = RX_D_VLD & (RX_PAR_ERR | RX_STP_ERR);
`else
    logic                  unused_err_s;
    assign unused_err_s = RX_PAR_ERR ^ RX_STP_ERR;
    assign byte_err_s   = 1'b0;
`endif

    // Next-state, strobe and held-field computation
    always_comb begin
        state_d       = state_q;
        rf_wr_en_d    = 1'b0;
        rf_rd_en_d    = 1'b0;
        alu_en_d      = 1'b0;
        overrun_d     = 1'b0;
        rf_addr_d     = rf_addr_q;
        rf_wr_data_d  = rf_wr_data_q;
        alu_fun_d     = alu_fun_q;
        clk_gate_en_d = clk_gate_en_q;

        // While waiting, bytes are never parsed, even in the cycle the ack releases us
        if (state_q == ST_WAIT_RSP) begin
            overrun_d = RX_D_VLD;
            if (RSP_ACK) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_WAIT_RSP;
            end
        end else if (byte_err_s) begin
            state_d = ST_IDLE;
        end else if (RX_D_VLD) begin
            case (state_q)
                ST_IDLE: begin
                    case (RX_P_DATA)
                        CMD_RF_WR:   state_d = ST_WR_ADDR;
                        CMD_RF_RD:   state_d = ST_RD_ADDR;
                        CMD_ALU_OP: begin
                            state_d       = ST_OP_A;
                            clk_gate_en_d = 1'b1;
                        end
                        CMD_ALU_NOP: begin
                            state_d       = ST_ALU_FN;
                            clk_gate_en_d = 1'b1;
                        end
                        default:     state_d = ST_IDLE;
                    endcase
                end
                ST_WR_ADDR: begin
                    rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    rf_wr_data_d = RX_P_DATA;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_IDLE;
                end
                ST_RD_ADDR: begin
                    rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = ST_WAIT_RSP;
                end
                ST_OP_A: begin
                    rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
                    rf_wr_data_d = RX_P_DATA;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_OP_B;
                end
                ST_OP_B: begin
                    rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
                    rf_wr_data_d = RX_P_DATA;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_ALU_FN;
                end
                ST_ALU_FN: begin
                    alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = ST_WAIT_RSP;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        // The ALU clock gate only survives while a CC/DD frame is still in flight
        if (state_d == ST_IDLE) begin
            clk_gate_en_d = 1'b0;
        end else begin
            clk_gate_en_d = clk_gate_en_d;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output update with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            rf_wr_en_q    <= 1'b0;
            rf_rd_en_q    <= 1'b0;
            rf_addr_q     <= '0;
            rf_wr_data_q  <= '0;
            alu_en_q      <= 1'b0;
            alu_fun_q     <= '0;
            clk_gate_en_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rf_wr_en_q    <= rf_wr_en_d;
            rf_rd_en_q    <= rf_rd_en_d;
            rf_addr_q     <= rf_addr_d;
            rf_wr_data_q  <= rf_wr_data_d;
            alu_en_q      <= alu_en_d;
            alu_fun_q     <= alu_fun_d;
            clk_gate_en_q <= clk_gate_en_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

`ifdef UART_CMD_ERR_DROP_EN
    // Errored bytes only count as frame errors when not already waiting for a response
    always_comb begin
        frame_err_d = byte_err_s & (state_q != ST_WAIT_RSP);
    end

    // Frame-error pulse register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign FRAME_ERR = frame_err_q;
`endif

    assign RF_WR_EN    = rf_wr_en_q;
    assign RF_RD_EN    = rf_rd_en_q;
    assign RF_ADDR     = rf_addr_q;
    assign RF_WR_DATA  = rf_wr_data_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = clk_gate_en_q;
    assign OVERRUN     = overrun_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Self-checking bench: frame-level reference model compared every cycle, plus directed literal checks.
module tb_uart_rx_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vld = 1'b0;
    logic       par = 1'b0;
    logic       stp = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr_en, rd_en, alu_en, gate, ovr, busy;
    logic [3:0] addr, fun;
    logic [7:0] wdata;
`ifdef UART_CMD_ERR_DROP_EN
    logic       frame_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_rx_cmd_parser dut (
        .CLK(clk), .RST(rst), .RX_P_DATA(din), .RX_D_VLD(vld),
        .RX_PAR_ERR(par), .RX_STP_ERR(stp), .RSP_ACK(ack),
        .RF_WR_EN(wr_en), .RF_RD_EN(rd_en), .RF_ADDR(addr), .RF_WR_DATA(wdata),
        .ALU_EN(alu_en), .ALU_FUN(fun), .CLK_GATE_EN(gate), .OVERRUN(ovr),
`ifdef UART_CMD_ERR_DROP_EN
        .FRAME_ERR(frame_err),
`endif
        .BUSY(busy)
    );

    // Reference model: bytes of the frame in progress, plus a "waiting for response" flag
    logic [7:0] frame[$];
    bit         waiting   = 1'b0;
    bit         alu_wait  = 1'b0;
    logic       m_wr = 1'b0, m_rd = 1'b0, m_alu = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
    logic       m_gate = 1'b0, m_busy = 1'b0;
    logic [3:0] m_addr = 4'h0, m_fun = 4'h0;
    logic [7:0] m_data = 8'h00;

    function automatic int frame_len(input logic [7:0] op);
        case (op)
            8'hAA:   return 3;
            8'hBB:   return 2;
            8'hCC:   return 4;
            8'hDD:   return 2;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [7:0] op;
        int         pos;
        bit         berr;
        m_wr = 1'b0; m_rd = 1'b0; m_alu = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
`ifdef UART_CMD_ERR_DROP_EN
        berr = par | stp;
`else
        berr = 1'b0;
`endif
        if (!rst) begin
            frame.delete();
            waiting = 1'b0; alu_wait = 1'b0;
            m_addr = 4'h0; m_data = 8'h00; m_fun = 4'h0;
        end else if (waiting) begin
            if (vld) m_ovr = 1'b1;
            if (ack) begin waiting = 1'b0; alu_wait = 1'b0; end
        end else if (vld && berr) begin
            frame.delete();
            m_ferr = 1'b1;
        end else if (vld) begin
            frame.push_back(din);
            op  = frame[0];
            pos = frame.size() - 1;
            if (op == 8'hAA && pos == 1) m_addr = din[3:0];
            if (op == 8'hAA && pos == 2) begin m_data = din; m_wr = 1'b1; end
            if (op == 8'hBB && pos == 1) begin m_addr = din[3:0]; m_rd = 1'b1; end
            if (op == 8'hCC && (pos == 1 || pos == 2)) begin
                m_addr = 4'(pos - 1); m_data = din; m_wr = 1'b1;
            end
            if ((op == 8'hCC && pos == 3) || (op == 8'hDD && pos == 1)) begin
                m_fun = din[3:0]; m_alu = 1'b1;
            end
            if (frame.size() >= frame_len(op)) begin
                waiting  = (op != 8'hAA) && (frame_len(op) != 0);
                alu_wait = (op == 8'hCC) || (op == 8'hDD);
                frame.delete();
            end
        end
        m_gate = alu_wait || (frame.size() != 0 && (frame[0] == 8'hCC || frame[0] == 8'hDD));
        m_busy = waiting || frame.size() != 0;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        cmp("wr_en", 32'(wr_en), 32'(m_wr));
        cmp("rd_en", 32'(rd_en), 32'(m_rd));
        cmp("alu_en", 32'(alu_en), 32'(m_alu));
        cmp("overrun", 32'(ovr), 32'(m_ovr));
        cmp("addr", 32'(addr), 32'(m_addr));
        cmp("wdata", 32'(wdata), 32'(m_data));
        cmp("fun", 32'(fun), 32'(m_fun));
        cmp("gate", 32'(gate), 32'(m_gate));
        cmp("busy", 32'(busy), 32'(m_busy));
`ifdef UART_CMD_ERR_DROP_EN
        cmp("frame_err", 32'(frame_err), 32'(m_ferr));
`endif
    end

    task automatic cyc(input logic v, input logic [7:0] b, input logic a);
        vld = v; din = b; ack = a;
        @(negedge clk);
        #1;
        vld = 1'b0; ack = 1'b0;
    endtask

    logic [7:0] ops [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        // Reset state
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        cmp("rst busy", 32'(busy), 32'h0);
        cmp("rst addr", 32'(addr), 32'h0);
        cmp("rst wdata", 32'(wdata), 32'h0);
        cmp("rst gate", 32'(gate), 32'h0);
        rst = 1'b1;

        // Write frame
        cyc(1'b1, 8'hAA, 1'b0);
        cmp("wr busy", 32'(busy), 32'h1);
        cyc(1'b1, 8'h05, 1'b0);
        cyc(1'b1, 8'h3C, 1'b0);
        cmp("wr strobe", 32'(wr_en), 32'h1);
        cmp("wr addr", 32'(addr), 32'h5);
        cmp("wr data", 32'(wdata), 32'h3C);
        cyc(1'b0, 8'h00, 1'b0);
        cmp("wr end strobe", 32'(wr_en), 32'h0);
        cmp("wr end busy", 32'(busy), 32'h0);

        // Read frame with address truncation, held until ack
        cyc(1'b1, 8'hBB, 1'b0);
        cyc(1'b1, 8'h12, 1'b0);
        cmp("rd strobe", 32'(rd_en), 32'h1);
        cmp("rd addr", 32'(addr), 32'h2);
        cmp("rd gate", 32'(gate), 32'h0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        cmp("rd wait busy", 32'(busy), 32'h1);
        cyc(1'b0, 8'h00, 1'b1);
        cmp("rd ack busy", 32'(busy), 32'h0);

        // ALU operand frame
        cyc(1'b1, 8'hCC, 1'b0);
        cmp("op gate", 32'(gate), 32'h1);
        cyc(1'b1, 8'h07, 1'b0);
        cmp("opa wr", 32'(wr_en), 32'h1);
        cmp("opa addr", 32'(addr), 32'h0);
        cmp("opa data", 32'(wdata), 32'h07);
        cyc(1'b1, 8'h03, 1'b0);
        cmp("opb addr", 32'(addr), 32'h1);
        cmp("opb data", 32'(wdata), 32'h03);
        cyc(1'b1, 8'h01, 1'b0);
        cmp("op alu_en", 32'(alu_en), 32'h1);
        cmp("op fun", 32'(fun), 32'h1);
        cyc(1'b0, 8'h00, 1'b0);
        cmp("op wait gate", 32'(gate), 32'h1);
        cyc(1'b0, 8'h00, 1'b1);
        cmp("op ack gate", 32'(gate), 32'h0);

        // Ignored byte, then ALU-only frame, then overrun on the ack cycle
        cyc(1'b1, 8'h55, 1'b0);
        cmp("ign busy", 32'(busy), 32'h0);
        cyc(1'b1, 8'hDD, 1'b0);
        cyc(1'b1, 8'h0A, 1'b0);
        cmp("nop alu_en", 32'(alu_en), 32'h1);
        cmp("nop fun", 32'(fun), 32'hA);
        cmp("nop wr", 32'(wr_en), 32'h0);
        cyc(1'b1, 8'hAA, 1'b1);
        cmp("ovr pulse", 32'(ovr), 32'h1);
        cmp("ovr busy", 32'(busy), 32'h0);
        cyc(1'b1, 8'hAA, 1'b0);
        cyc(1'b1, 8'h09, 1'b0);
        cyc(1'b1, 8'h77, 1'b0);
        cmp("post ovr addr", 32'(addr), 32'h9);
        cmp("post ovr data", 32'(wdata), 32'h77);

        // Mid-frame reset discards the partial frame
        cyc(1'b1, 8'hCC, 1'b0);
        cyc(1'b1, 8'h07, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        cmp("mid rst gate", 32'(gate), 32'h0);
        cmp("mid rst busy", 32'(busy), 32'h0);
        cmp("mid rst data", 32'(wdata), 32'h0);
        rst = 1'b1;
        cyc(1'b1, 8'h03, 1'b0);
        cmp("mid rst ignore", 32'(wr_en), 32'h0);
        cmp("mid rst idle", 32'(busy), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom % 150) != 0;
            par = ($urandom % 10) == 0;
            stp = ($urandom % 10) == 0;
            cyc(($urandom % 3) == 0,
                ($urandom % 2) ? ops[$urandom % 4] : 8'($urandom),
                ($urandom % 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
